cntr_prog: RTL
==============

Name: cntr_prog

Overview:
Parametrised, programmable successor to the team's free-running enable counter. Adds synchronous clear and load, up/down direction, a programmable limit, wrap/saturate/one-shot modes, an enable prescaler, a terminal-count pulse and a sticky done flag. Sits beside the existing counters as the general-purpose timer/tick source for peripheral blocks.

Parameters:
COUNT_WIDTH, 8, width of count, limit and load_val
PRESC_WIDTH, 4, width of prescaler setting; tick every presc+1 enabled cycles

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  count enable; gates the prescaler
clr  input  1  synchronous clear
load  input  1  synchronous load of load_val
load_val  input  COUNT_WIDTH  value written on load
dir  input  1  1 = count up, 0 = count down
mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
limit  input  COUNT_WIDTH  terminal value for up, start value for down
presc  input  PRESC_WIDTH  prescale divide-minus-one
count  output  COUNT_WIDTH  registered count
tc  output  1  registered one-cycle terminal-count pulse
done  output  1  sticky one-shot completion flag

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (rst_n low, async): count=0, tc=0, done=0, prescaler counter pc=0. These values hold until the first rising edge after deassertion.
- Priority each edge: clr > load > step.
- clr: count=0, pc=0, done=0, tc=0.
- load: count=load_val, pc=0, done=0, tc=0.
- Prescaler: active only when ena=1, clr=0 and load=0.
  - If pc==presc: pc<=0 and tick=1 (combinational, same cycle).
  - Otherwise pc<=pc+1.
  - presc=0 gives a tick on every enabled cycle. ena=0 freezes pc.
- Step qualifier: step = tick & ~done.
- Terminal test, evaluated on current count:
  - Up: at_term = (count >= limit).
  - Down: at_term = (count == 0).
- Step when not at_term: count +/- 1.
- Step when at_term:
  - Wrap: reload start value (0 for up, limit for down).
  - Saturate: hold; no advance.
  - One-shot: hold; no advance.
- Advance: a step that changes count or performs a wrap reload.
- tc: tc<=1 for one cycle when an advance produces next count equal to terminal (limit for up, 0 for down); otherwise tc<=0.
  - Saturate and one-shot produce exactly one tc on arrival.
  - Wrap produces tc once per period.
  - limit=0 in up/wrap: count stays 0 and tc=1 on every step.
- done: set on the same edge as tc when mode=one-shot. Stays set until clr, load or reset, and blocks further steps.
- Load above limit:
  - Up: at_term is immediately true (wrap reloads 0, saturate holds).
  - Down: counts down normally.
- dir, mode, limit and presc are sampled every cycle. Changes take effect on the next step with no pipeline flush. Changing presc below the current pc delays the next tick until pc wraps at all-ones.
- Arithmetic is modulo 2^COUNT_WIDTH; no overflow path beyond the rules above.
- Latency: count, tc and done update one edge after the qualifying input.

Decomposition:
- Shared header holds mode encodings: MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10.
- Sub-module cntr_presc (ports: clk, rst_n, ena, clr, presc, tick) isolates the prescaler. Its clr input is driven by clr|load.
- Step, terminal and tc logic stay in cntr_prog.

Test Plan:
1. Reset mid-count: async rst_n low with count=5 -> count=0, tc=0, done=0 immediately, without waiting for a clock edge.
2. Up wrap: COUNT_WIDTH=8, limit=3, presc=0, ena=1 -> count 0,1,2,3,0,1...; tc high exactly in cycles showing 3.
3. Down saturate: load_val=2, dir=0, mode=01 -> count 2,1,0,0,0; single tc when 0 first appears.
4. One-shot up with prescaler: limit=2, presc=2 -> count steps every 3rd enabled cycle to 2; tc and done rise together; later ticks leave count=2. load then clears done.
5. Priority: clr=1, load=1 and a tick in the same cycle -> count=0, pc=0. load alone with ena=1 -> count=load_val and no step that cycle.
6. Up past limit and gated enable: load_val=9, limit=5, mode=00 -> next step gives count=0, no tc. Toggling ena=0 freezes count and pc.

Source files
------------

// File: rtl/cntr_prog_pkg.sv
// Shared definitions for the programmable counter: mode encodings and a
// helper that tells which modes stop at the terminal value.
package cntr_prog_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } cntr_mode_e;

    // Saturate and one-shot hold at the terminal value; wrap and reserved reload.
    function automatic logic holds_at_term(input cntr_mode_e m);
        return (m == MODE_SAT) || (m == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/cntr_presc.sv
// Enable prescaler: emits a one-cycle tick every presc+1 enabled cycles.
module cntr_presc
    import cntr_prog_pkg::*;
#(
    parameter int PRESC_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   clr,
    input  logic [PRESC_WIDTH-1:0] presc,
    output logic                   tick
);

    localparam logic [PRESC_WIDTH-1:0] PC_ONE = 1;

    logic [PRESC_WIDTH-1:0] pc;

    assign tick = ena && !clr && (pc == presc);

    // If presc drops below pc, pc keeps counting and wraps through all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (ena) begin
            if (pc == presc) begin
                pc <= '0;
            end else begin
                pc <= pc + PC_ONE;
            end
        end
    end

endmodule

// File: rtl/cntr_prog.sv
// Programmable up/down counter with wrap/saturate/one-shot modes, prescaled
// enable, terminal-count pulse and sticky done flag.
module cntr_prog
    import cntr_prog_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int PRESC_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   clr,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_val,
    input  logic                   dir,
    input  logic [1:0]             mode,
    input  logic [COUNT_WIDTH-1:0] limit,
    input  logic [PRESC_WIDTH-1:0] presc,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   tc,
    output logic                   done
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;

    cntr_mode_e             mode_e;
    logic                   tick;
    logic                   step;
    logic                   at_term;
    logic                   advance;
    logic                   hit;
    logic [COUNT_WIDTH-1:0] next_count;
    logic [COUNT_WIDTH-1:0] term_val;

    assign mode_e = cntr_mode_e'(mode);

    cntr_presc #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .clr  (clr | load),
        .presc(presc),
        .tick (tick)
    );

    assign step     = tick && !done;
    assign at_term  = dir ? (count >= limit) : (count == '0);
    assign term_val = dir ? limit : '0;

    // An advance is either a +/-1 move or a wrap reload; holds do not count.
    always_comb begin
        next_count = count;
        advance    = 1'b0;
        if (step) begin
            if (!at_term) begin
                next_count = dir ? (count + CNT_ONE) : (count - CNT_ONE);
                advance    = 1'b1;
            end else if (!holds_at_term(mode_e)) begin
                next_count = dir ? '0 : limit;
                advance    = 1'b1;
            end
        end
    end

    assign hit = advance && (next_count == term_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            count <= load_val;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            count <= next_count;
            tc    <= hit;
            if (hit && (mode_e == MODE_ONESHOT)) begin
                done <= 1'b1;
            end
        end
    end

endmodule
